// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: flag capture, 2-entry register-file write queue,
// and a pending-write hazard check for decode.
module alu_writeback_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              carry,
  input  logic              zero,
  input  logic [5:0]        ctrl,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              flush,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ack,
  output logic              flag_c,
  output logic              flag_z,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              pending_hit,
  output logic [7:0]        retired
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t     head_q;
  entry_t     tail_q;
  entry_t     new_e;
  logic [1:0] count_q;
  logic [1:0] count_nxt;
  logic       accept;
  logic       enq;
  logic       deq;
  logic       flag_op;

  assign accept  = in_valid & in_ready & ~flush;
  assign enq     = accept & wr_req;
  assign deq     = rf_we & rf_ack & ~flush;
  assign flag_op = ctrl inside {6'b000000, 6'b000001, 6'b000010,
                                6'b000110, 6'b001111};
  assign new_e   = '{addr: dest_addr, data: alu_out};

  assign rf_we    = (count_q != 2'd0);
  assign rf_waddr = head_q.addr;
  assign rf_wdata = head_q.data;

  assign pending_hit =
    (rf_we && head_q.addr == query_addr) ||
    (count_q == FULL && tail_q.addr == query_addr);

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      unique case ({enq, deq})
        2'b10:   count_nxt = count_q + 2'd1;
        2'b01:   count_nxt = count_q - 2'd1;
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      in_ready <= 1'b1;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      retired  <= 8'd0;
    end else begin
      count_q  <= count_nxt;
      in_ready <= (count_nxt < FULL);
      if (deq)
        retired <= retired + 8'd1;
      if (accept && flag_op) begin
        flag_c <= carry;
        flag_z <= zero;
      end
      // Head keeps its last value when drained so rf_waddr/rf_wdata hold.
      if (enq) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && deq))
          head_q <= new_e;
        else
          tail_q <= new_e;
      end else if (deq && count_q == FULL) begin
        head_q <= tail_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: scoreboarded RF writes
// plus directed flag, hazard, flush, reset and wrap checks.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic        carry;
  logic        zero;
  logic [5:0]  ctrl;
  logic        wr_req;
  logic [2:0]  dest_addr;
  logic        flush;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ack;
  logic        flag_c;
  logic        flag_z;
  logic [2:0]  query_addr;
  logic        pending_hit;
  logic [7:0]  retired;

  int n_tests = 0;
  int n_fail  = 0;

  logic [18:0] sb_q[$];
  logic [7:0]  exp_ret = 8'd0;
  logic        exp_c   = 1'b0;
  logic        exp_z   = 1'b0;

  always #5 clk = ~clk;

  alu_writeback_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .carry(carry), .zero(zero),
    .ctrl(ctrl), .wr_req(wr_req), .dest_addr(dest_addr),
    .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_ack(rf_ack),
    .flag_c(flag_c), .flag_z(flag_z),
    .query_addr(query_addr), .pending_hit(pending_hit),
    .retired(retired)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_flag_op(input logic [5:0] c);
    return c == 6'd0 || c == 6'd1 || c == 6'd2 ||
           c == 6'd6 || c == 6'd15;
  endfunction

  // Model update at negedge: transfers commit on the following posedge.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (rf_we && rf_ack) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          logic [18:0] e;
          e = sb_q.pop_front();
          chk("sb_addr", 32'(rf_waddr), 32'(e[18:16]));
          chk("sb_data", 32'(rf_wdata), 32'(e[15:0]));
        end
        exp_ret = exp_ret + 8'd1;
      end
      if (in_valid && in_ready) begin
        if (wr_req)
          sb_q.push_back({dest_addr, alu_out});
        if (is_flag_op(ctrl)) begin
          exp_c = carry;
          exp_z = zero;
        end
      end
    end else if (rst_n && flush) begin
      sb_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] c,
                       input logic [15:0] d, input logic cy,
                       input logic z, input logic w,
                       input logic [2:0] a);
    in_valid  = v;
    ctrl      = c;
    alu_out   = d;
    carry     = cy;
    zero      = z;
    wr_req    = w;
    dest_addr = a;
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_ret = 8'd0;
    exp_c   = 1'b0;
    exp_z   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ret_s;
    logic       c_s;
    logic       z_s;
    rst_n = 1'b0;
    drive(0, 6'd0, 16'h0, 0, 0, 0, 3'd0);
    flush = 0;
    rf_ack = 0;
    query_addr = 3'd0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_c", 32'(flag_c), 32'd0);
    chk("rst_z", 32'(flag_z), 32'd0);
    chk("rst_ret", 32'(retired), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single write, one-cycle latency
    drive(1, 6'b000010, 16'h0000, 1, 0, 1, 3'd3);
    tick();
    drive(0, 6'd0, 16'h0, 0, 0, 0, 3'd0);
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_waddr", 32'(rf_waddr), 32'd3);
    chk("t1_wdata", 32'(rf_wdata), 32'h0);
    chk("t1_c", 32'(flag_c), 32'd1);
    chk("t1_z", 32'(flag_z), 32'd0);
    rf_ack = 1;
    tick();
    rf_ack = 0;
    chk("t1_ret", 32'(retired), 32'd1);
    chk("t1_we_off", 32'(rf_we), 32'd0);

    // Fill to full, third input ignored
    drive(1, 6'b000000, 16'h1111, 0, 0, 1, 3'd1);
    tick();
    drive(1, 6'b000001, 16'h2222, 1, 0, 1, 3'd2);
    tick();
    chk("t2_full", 32'(in_ready), 32'd0);
    drive(1, 6'b000000, 16'h3333, 0, 1, 1, 3'd4);
    tick();
    drive(0, 6'd0, 16'h0, 0, 0, 0, 3'd0);
    chk("t2_c", 32'(flag_c), 32'd1);
    chk("t2_z", 32'(flag_z), 32'd0);
    chk("t2_head", 32'(rf_waddr), 32'd1);
    rf_ack = 1;
    tick();
    chk("t2_second", 32'(rf_wdata), 32'h2222);
    tick();
    rf_ack = 0;
    chk("t2_ret", 32'(retired), 32'd3);
    chk("t2_empty", 32'(rf_we), 32'd0);
    chk("t2_hold", 32'(rf_wdata), 32'h2222);

    // Undefined ctrl keeps flags; wr_req=0 updates flags only
    drive(1, 6'b000011, 16'h0, 0, 1, 0, 3'd0);
    tick();
    chk("t3_c", 32'(flag_c), 32'd1);
    chk("t3_z", 32'(flag_z), 32'd0);
    drive(1, 6'b000110, 16'h0, 0, 1, 0, 3'd0);
    tick();
    drive(0, 6'd0, 16'h0, 0, 0, 0, 3'd0);
    chk("t3_z1", 32'(flag_z), 32'd1);
    chk("t3_c0", 32'(flag_c), 32'd0);
    chk("t3_nowe", 32'(rf_we), 32'd0);

    // Hazard check
    drive(1, 6'b000011, 16'h5555, 0, 0, 1, 3'd5);
    tick();
    drive(0, 6'd0, 16'h0, 0, 0, 0, 3'd0);
    query_addr = 3'd5;
    #1;
    chk("t4_hit5", 32'(pending_hit), 32'd1);
    query_addr = 3'd4;
    #1;
    chk("t4_miss4", 32'(pending_hit), 32'd0);
    rf_ack = 1;
    tick();
    rf_ack = 0;
    query_addr = 3'd5;
    #1;
    chk("t4_gone5", 32'(pending_hit), 32'd0);

    // Flush with concurrent in_valid and rf_ack
    drive(1, 6'b001111, 16'h6666, 1, 1, 1, 3'd6);
    tick();
    drive(1, 6'b000000, 16'h7777, 0, 0, 1, 3'd7);
    tick();
    query_addr = 3'd7;
    #1;
    chk("t5_hit_tail", 32'(pending_hit), 32'd1);
    chk("t5_full", 32'(in_ready), 32'd0);
    ret_s = retired;
    c_s = flag_c;
    z_s = flag_z;
    drive(1, 6'b000000, 16'h8888, 0, 0, 1, 3'd2);
    flush = 1;
    rf_ack = 1;
    tick();
    flush = 0;
    rf_ack = 0;
    drive(0, 6'd0, 16'h0, 0, 0, 0, 3'd0);
    chk("t5_we", 32'(rf_we), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_ret", 32'(retired), 32'(ret_s));
    chk("t5_c", 32'(flag_c), 32'(c_s));
    chk("t5_z", 32'(flag_z), 32'(z_s));
    chk("t5_ret_m", 32'(retired), 32'(exp_ret));
    query_addr = 3'd6;
    #1;
    chk("t5_nohit", 32'(pending_hit), 32'd0);

    // Asynchronous reset mid-cycle with two entries queued
    drive(1, 6'b000000, 16'h9999, 1, 1, 1, 3'd1);
    tick();
    drive(1, 6'b000001, 16'hAAAA, 1, 1, 1, 3'd2);
    tick();
    drive(0, 6'd0, 16'h0, 0, 0, 0, 3'd0);
    chk("t6_pre_c", 32'(flag_c), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_we", 32'(rf_we), 32'd0);
    chk("t6_c", 32'(flag_c), 32'd0);
    chk("t6_z", 32'(flag_z), 32'd0);
    chk("t6_ret", 32'(retired), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    tick();

    // 256 back-to-back retirements wrap the counter
    rf_ack = 1;
    for (int i = 0; i < 256; i++) begin
      drive(1, 6'b000010, 16'($urandom), 1'($urandom),
            1'($urandom), 1, 3'($urandom));
      tick();
      if (i == 100)
        chk("t7_ready", 32'(in_ready), 32'd1);
    end
    drive(0, 6'd0, 16'h0, 0, 0, 0, 3'd0);
    tick();
    rf_ack = 0;
    chk("t7_wrap", 32'(retired), 32'd0);
    chk("t7_ret_m", 32'(retired), 32'(exp_ret));
    chk("t7_c", 32'(flag_c), 32'(exp_c));
    chk("t7_z", 32'(flag_z), 32'(exp_z));
    chk("t7_drained", 32'(rf_we), 32'd0);
    chk("t7_sb_left", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
